fifo_flex: RTL
==============

Name: fifo_flex

Overview:
Synchronous single-clock FIFO and the parametrised successor of the basic fifo block. Supports any depth ≥2, including non-power-of-two depths. Selectable registered-read or first-word-fall-through (FWFT) output mode. Adds an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and overflow/underflow error pulses. Used as the general buffering primitive between pipeline stages and peripheral datapaths.

Parameters:
Depth, 8, number of entries; any integer ≥2; no power-of-two requirement.
EntrySize, 8, width of one entry in bits.
Fwft, 0, 0 = registered read (data one cycle after accepted read); 1 = first-word fall-through.
AlmostFullLevel, Depth-1, almost_full_o asserted when level ≥ this value; legal range 1..Depth.
AlmostEmptyLevel, 1, almost_empty_o asserted when level ≤ this value; legal range 0..Depth-1.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  synchronous active-high reset.
flush_i  input  1  synchronous discard of all stored entries.
write_req_i  input  1  write request.
write_valid_o  output  1  FIFO can accept a write this cycle (not full).
data_i  input  EntrySize  write data.
read_req_i  input  1  read/pop request.
read_valid_o  output  1  FIFO holds ≥1 entry.
data_o  output  EntrySize  read data (timing per Fwft).
level_o  output  $clog2(Depth+1)  current number of stored entries, 0..Depth.
almost_full_o  output  1  level_o ≥ AlmostFullLevel.
almost_empty_o  output  1  level_o ≤ AlmostEmptyLevel.
overflow_o  output  1  one-cycle pulse: previous cycle had write_req_i while full.
underflow_o  output  1  one-cycle pulse: previous cycle had read_req_i while empty.

Behaviour:
- Priority: rst_i > flush_i > read/write.
- Reset values: level 0, both indices 0, write_valid_o=1, read_valid_o=0, almost_full_o=0 (AlmostFullLevel≥1), almost_empty_o=1, overflow_o=0, underflow_o=0, data_o=0.
- Write acceptance: write accepted when write_req_i && level<Depth. A write while full is dropped; no pass-through, even with a simultaneous read.
- Read acceptance: read accepted when read_req_i && level>0. A read while empty is dropped, even with a simultaneous write.
- Level update, registered:
  - accepted write only: +1.
  - accepted read only: −1.
  - both accepted: unchanged.
  - level_o and all flags derive from the registered level and are valid the same cycle.
- Indices: read and write indices wrap from Depth-1 to 0. Wrap must be correct for non-power-of-two Depth; the index must never reach the value Depth.
- Fwft=0:
  - data_o is a register loaded with the head entry on the edge that accepts a read.
  - Data is valid from the cycle after acceptance; otherwise data_o holds its value.
  - Read latency is 1 cycle.
- Fwft=1:
  - Whenever read_valid_o=1, data_o equals the oldest stored entry with zero latency.
  - After an accepted read, the next entry (if any) appears the following cycle.
  - A write into an empty FIFO appears on data_o the cycle after the write, with read_valid_o=1.
  - data_o is don't-care while read_valid_o=0.
- Flush:
  - Next cycle: level 0, indices 0, read_valid_o=0.
  - Same-cycle read/write requests are ignored and raise no overflow/underflow.
  - Fwft=0: data_o holds its value.
- Error pulses: overflow_o and underflow_o are registered and high exactly one cycle per offending request cycle. Back-to-back offending cycles give back-to-back pulses.
- Memory contents need no reset. Storage is written only on accepted writes.

Test Plan:
1. Depth=5, Fwft=0: write 0x11..0x55, then 6th write → write_valid_o=0 at level 5; next cycle overflow_o=1 for one cycle; level_o stays 5.
2. Depth=5, Fwft=0: 8 interleaved write/read cycles crossing wrap → data_o sequence matches write order, each value one cycle after its read accept; indices never equal 5.
3. Depth=8, Fwft=1: write 0xA5 into empty → next cycle read_valid_o=1, data_o=0xA5 with no read issued; pop → read_valid_o=0 next cycle.
4. Full FIFO (Depth=4) with write_req_i and read_req_i together → read accepted, write dropped, level_o 4→3, overflow_o=1. Empty FIFO with both requests → write accepted, read dropped, level_o 0→1, underflow_o=1.
5. Depth=8, AlmostFullLevel=6, AlmostEmptyLevel=2: fill 0→8 and drain → almost_empty_o=1 at levels 0–2; almost_full_o=1 at levels 6–8.
6. Level 3: assert flush_i with write_req_i=1 → level_o=0 next cycle, no overflow pulse. Then assert rst_i at level 2 with read_req_i=1 → all reset values next cycle, data_o=0.

Source files
------------

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO for any depth >= 2, registered-read or FWFT output,
// with occupancy level, almost flags, synchronous flush and overflow/underflow pulses.
module fifo_flex #(
    parameter int Depth            = 8,
    parameter int EntrySize        = 8,
    parameter int Fwft             = 0,
    parameter int AlmostFullLevel  = Depth - 1,
    parameter int AlmostEmptyLevel = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         write_req_i,
    output logic                         write_valid_o,
    input  logic [EntrySize-1:0]         data_i,
    input  logic                         read_req_i,
    output logic                         read_valid_o,
    output logic [EntrySize-1:0]         data_o,
    output logic [$clog2(Depth+1)-1:0]   level_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);
    localparam int IW = $clog2(Depth);
    localparam int LW = $clog2(Depth + 1);

    logic [EntrySize-1:0] mem_q [Depth];
    logic [IW-1:0]        wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [LW-1:0]        level_q, level_d;
    logic [EntrySize-1:0] dout_q, dout_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d;
    logic                 full, empty, wr_ok, rd_ok;

    always_comb begin
        full     = level_q == LW'(Depth);
        empty    = level_q == '0;
        wr_ok    = write_req_i && !full && !flush_i;
        rd_ok    = read_req_i && !empty && !flush_i;
        ovf_d    = write_req_i && full && !flush_i;
        unf_d    = read_req_i && empty && !flush_i;
        // explicit wrap keeps indices below Depth for non-power-of-two sizes
        wr_idx_d = flush_i ? '0 : !wr_ok ? wr_idx_q : wr_idx_q == IW'(Depth - 1) ? '0 : wr_idx_q + 1'b1;
        rd_idx_d = flush_i ? '0 : !rd_ok ? rd_idx_q : rd_idx_q == IW'(Depth - 1) ? '0 : rd_idx_q + 1'b1;
        level_d  = flush_i ? '0 : level_q + LW'(wr_ok) - LW'(rd_ok);
        dout_d   = (Fwft == 0 && rd_ok) ? mem_q[rd_idx_q] : dout_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok && !rst_i) mem_q[wr_idx_q] <= data_i;
    end

    always_comb begin
        write_valid_o  = !full;
        read_valid_o   = !empty;
        level_o        = level_q;
        almost_full_o  = level_q >= LW'(AlmostFullLevel);
        almost_empty_o = level_q <= LW'(AlmostEmptyLevel);
        overflow_o     = ovf_q;
        underflow_o    = unf_q;
        data_o         = Fwft != 0 ? (empty ? '0 : mem_q[rd_idx_q]) : dout_q;
    end
endmodule
